tta_add_cluster: RTL and testbench

TTA_ADD_CLUSTER -- requirements
Module: tta_add_cluster

---
 rtl/tta_add_cluster.sv | 165 ++++++++++++++++
 tb/tb_tta_add_cluster.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tta_add_cluster.sv
// tta_add_cluster
//   N independent transport-triggered ALU lanes. Each lane has an operand
//   register (OPR) written through the operand port, and a trigger port whose
//   firing computes OPR op t_data. Results travel a LAT-deep pipeline and land
//   in a per-lane RDEPTH-entry result FIFO. A per-lane credit counter
//   (occupancy + in-flight) throttles triggers, so the FIFO can never overflow.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   o_we   [N]        operand write strobe per lane
//   o_data [N*XLEN]   operand data, lane i at [i*XLEN +: XLEN]
//   t_valid/t_ready   per-lane trigger handshake (fires on t_valid & t_ready)
//   t_op   [N*3]      opcode: ADD SUB AND OR XOR SLT SLTU MOV
//   t_data [N*XLEN]   second source operand
//   r_valid/r_ready   per-lane result handshake (pop on r_valid & r_ready)
//   r_data [N*XLEN]   head-of-FIFO result per lane
//   idle              no lane holds in-flight or queued results
module tta_add_cluster #(
    parameter int XLEN   = 32,
    parameter int N      = 4,
    parameter int LAT    = 2,
    parameter int RDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      o_we,
    input  logic [N*XLEN-1:0] o_data,
    input  logic [N-1:0]      t_valid,
    output logic [N-1:0]      t_ready,
    input  logic [N*3-1:0]    t_op,
    input  logic [N*XLEN-1:0] t_data,
    output logic [N-1:0]      r_valid,
    input  logic [N-1:0]      r_ready,
    output logic [N*XLEN-1:0] r_data,
    output logic              idle
);

    localparam int PW = $clog2(RDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CAP = CW'(RDEPTH);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_SLTU = 3'd6,
        OP_MOV  = 3'd7
    } op_e;

    logic [N-1:0] lane_idle;

    // Credits cover every in-flight and queued result, so zero credit on all
    // lanes is exactly "idle" and comes straight from registers.
    assign idle = &lane_idle;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [XLEN-1:0] opr;
        logic [XLEN-1:0] opa;
        logic [XLEN-1:0] opb;
        logic [XLEN-1:0] res;
        op_e             op;
        logic            fire;
        logic            pop;
        logic            push;
        logic [XLEN-1:0] push_data;
        logic [CW-1:0]   credit;
        logic [CW-1:0]   occ;
        logic [PW-1:0]   wptr;
        logic [PW-1:0]   rptr;
        logic [XLEN-1:0] mem [RDEPTH];

        assign op  = op_e'(t_op[i*3 +: 3]);
        assign opb = t_data[i*XLEN +: XLEN];
        // Write-through: a same-cycle operand write feeds the trigger directly.
        assign opa = o_we[i] ? o_data[i*XLEN +: XLEN] : opr;

        assign pop          = r_valid[i] & r_ready[i];
        // A pop this cycle frees a slot immediately, so a full lane can still
        // accept one trigger per popped result.
        assign t_ready[i]   = (credit < CAP) | pop;
        assign fire         = t_valid[i] & t_ready[i];
        assign r_valid[i]   = (occ != '0);
        assign r_data[i*XLEN +: XLEN] = mem[rptr];
        assign lane_idle[i] = (credit == '0);

        always_comb begin
            res = opb;
            case (op)
                OP_ADD:  res = opa + opb;
                OP_SUB:  res = opa - opb;
                OP_AND:  res = opa & opb;
                OP_OR:   res = opa | opb;
                OP_XOR:  res = opa ^ opb;
                OP_SLT:  res = XLEN'($signed(opa) < $signed(opb));
                OP_SLTU: res = XLEN'(opa < opb);
                OP_MOV:  res = opb;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                opr <= '0;
            end else if (o_we[i]) begin
                opr <= o_data[i*XLEN +: XLEN];
            end
        end

        // The FIFO write itself is the final latency stage, so only LAT-1
        // pipeline registers sit between the trigger and the FIFO.
        if (LAT == 1) begin : g_direct
            assign push      = fire;
            assign push_data = res;
        end else begin : g_pipe
            localparam int PVW = LAT - 1;
            localparam int PDW = (LAT - 1) * XLEN;
            logic [LAT-2:0]           pv;
            logic [LAT-2:0][XLEN-1:0] pd;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pv <= '0;
                end else begin
                    pv <= (pv << 1) | PVW'(fire);
                end
            end

            always_ff @(posedge clk) begin
                pd <= (pd << XLEN) | PDW'(res);
            end

            assign push      = pv[LAT-2];
            assign push_data = pd[LAT-2];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr   <= '0;
                rptr   <= '0;
                occ    <= '0;
                credit <= '0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: ;
                endcase
                case ({fire, pop})
                    2'b10:   credit <= credit + 1'b1;
                    2'b01:   credit <= credit - 1'b1;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem[wptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_tta_add_cluster.sv
// Self-checking bench for tta_add_cluster. Four parameter variants run side
// by side on one clock: default (LAT 2, RDEPTH 4), LAT 1, LAT 4, RDEPTH 2.
// Each variant keeps per-lane queues of {expected result, cycle it becomes
// visible}; the monitor derives r_valid, r_data, t_ready and idle from them.
module tb_tta_add_cluster;

    localparam int XLEN = 32;
    localparam int N    = 4;
    localparam int NV   = 4;

    typedef struct {
        logic [31:0] d;
        int          due;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [31:0] ref_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6:    return (a < b) ? 32'd1 : 32'd0;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(string nm, int v, int lane, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s variant %0d lane %0d: got %h expected %h (cycle %0d)",
                     nm, v, lane, act, exp, cyc);
        end
    endtask

    for (genvar v = 0; v < NV; v++) begin : g_v
        localparam int VLAT = (v == 1) ? 1 : (v == 2) ? 4 : 2;
        localparam int VRD  = (v == 3) ? 2 : 4;

        logic              rst_n = 1'b0;
        logic [N-1:0]      o_we;
        logic [N*XLEN-1:0] o_data;
        logic [N-1:0]      t_valid;
        logic [N-1:0]      t_ready;
        logic [N*3-1:0]    t_op;
        logic [N*XLEN-1:0] t_data;
        logic [N-1:0]      r_valid;
        logic [N-1:0]      r_ready;
        logic [N*XLEN-1:0] r_data;
        logic              idle;
        logic              done_v = 1'b0;

        ent_t        q [N][$];
        logic [31:0] opr_m [N];

        tta_add_cluster #(
            .XLEN  (XLEN),
            .N     (N),
            .LAT   (VLAT),
            .RDEPTH(VRD)
        ) dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .o_we   (o_we),
            .o_data (o_data),
            .t_valid(t_valid),
            .t_ready(t_ready),
            .t_op   (t_op),
            .t_data (t_data),
            .r_valid(r_valid),
            .r_ready(r_ready),
            .r_data (r_data),
            .idle   (idle)
        );

        // Monitor / scoreboard
        always @(negedge clk) begin : mon
            int          sz;
            logic        ev;
            logic        ep;
            logic        et;
            logic        eidle;
            logic [31:0] a;
            ent_t        e;
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    q[i].delete();
                    opr_m[i] = '0;
                end
            end
            eidle = 1'b1;
            for (int i = 0; i < N; i++) if (q[i].size() != 0) eidle = 1'b0;
            chk("idle", v, 0, 32'(idle), 32'(eidle));
            for (int i = 0; i < N; i++) begin
                sz = q[i].size();
                ev = (sz > 0) && (q[i][0].due <= cyc);
                ep = ev && r_ready[i];
                et = (sz < VRD) || ep;
                chk("r_valid", v, i, 32'(r_valid[i]), 32'(ev));
                if (ev) chk("r_data", v, i, r_data[i*XLEN +: XLEN], q[i][0].d);
                chk("t_ready", v, i, 32'(t_ready[i]), 32'(et));
                if (ep) void'(q[i].pop_front());
                if (rst_n) begin
                    a = o_we[i] ? o_data[i*XLEN +: XLEN] : opr_m[i];
                    if (o_we[i]) opr_m[i] = o_data[i*XLEN +: XLEN];
                    if (t_valid[i] && et) begin
                        e.d   = ref_op(t_op[i*3 +: 3], a, t_data[i*XLEN +: XLEN]);
                        e.due = cyc + VLAT;
                        q[i].push_back(e);
                    end
                end
            end
        end

        task automatic step();
            @(posedge clk);
            #1;
        endtask

        task automatic trig_chk(int ln, logic we, logic [31:0] wd, logic [2:0] op,
                                logic [31:0] td, logic [31:0] exp);
            o_we[ln]              = we;
            o_data[ln*XLEN +: XLEN] = wd;
            t_valid[ln]           = 1'b1;
            t_op[ln*3 +: 3]       = op;
            t_data[ln*XLEN +: XLEN] = td;
            step();
            o_we[ln]    = 1'b0;
            t_valid[ln] = 1'b0;
            repeat (VLAT - 1) @(posedge clk);
            @(negedge clk);
            chk("lat_valid", v, ln, 32'(r_valid[ln]), 32'd1);
            chk("lat_data", v, ln, r_data[ln*XLEN +: XLEN], exp);
            step();
        endtask

        initial begin : stim
            o_we = '0; o_data = '0; t_valid = '0; t_op = '0; t_data = '0; r_ready = '0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            step();

            // Lane 0: write 5, then ADD 3 -> 8 after LAT; idle after pop
            r_ready = '1;
            o_we[0] = 1'b1; o_data[31:0] = 32'h5;
            step();
            o_we[0] = 1'b0;
            trig_chk(0, 1'b0, 32'h0, 3'd0, 32'h3, 32'h8);
            @(negedge clk);
            chk("idle_after_pop", v, 0, 32'(idle), 32'd1);
            step();

            // Lane 1: bypassed write of -1, signed vs unsigned compare with 0
            trig_chk(1, 1'b1, 32'hFFFF_FFFF, 3'd5, 32'h0, 32'h1);
            trig_chk(1, 1'b0, 32'h0, 3'd6, 32'h0, 32'h0);

            // Lane 2: saturate credits, single-cycle pop admits exactly one
            r_ready[2] = 1'b0; t_valid[2] = 1'b1; t_op[8:6] = 3'd7;
            for (int k = 0; k < VRD + VLAT + 2; k++) begin
                t_data[2*XLEN +: XLEN] = 32'h100 + k;
                step();
            end
            @(negedge clk);
            chk("full_tready", v, 2, 32'(t_ready[2]), 32'd0);
            step();
            r_ready[2] = 1'b1; t_data[2*XLEN +: XLEN] = 32'h200;
            @(negedge clk);
            chk("pop_tready", v, 2, 32'(t_ready[2]), 32'd1);
            step();
            r_ready[2] = 1'b0; t_data[2*XLEN +: XLEN] = 32'h300;
            @(negedge clk);
            chk("refull_tready", v, 2, 32'(t_ready[2]), 32'd0);
            step();
            t_valid[2] = 1'b0; r_ready[2] = 1'b1;
            repeat (VRD + VLAT + 3) step();

            // All lanes: 0 - 1 every cycle at full throughput
            o_we = '1; o_data = '0;
            step();
            o_we = '0; r_ready = '1; t_valid = '1;
            for (int i = 0; i < N; i++) begin
                t_op[i*3 +: 3] = 3'd1;
                t_data[i*XLEN +: XLEN] = 32'h1;
            end
            for (int k = 0; k < 20; k++) begin
                if (k == 10) begin
                    @(negedge clk);
                    for (int i = 0; i < N; i++)
                        chk("sub_result", v, i, r_data[i*XLEN +: XLEN], 32'hFFFF_FFFF);
                end
                step();
            end
            t_valid = '0;
            repeat (VLAT + 2) step();

            // Lane 3: reset with results queued and in flight
            r_ready[3] = 1'b0; t_valid[3] = 1'b1; t_op[11:9] = 3'd0;
            t_data[3*XLEN +: XLEN] = 32'h7;
            step();
            t_valid[3] = 1'b0;
            repeat (VLAT) step();
            t_valid[3] = 1'b1;
            step();
            #2 rst_n = 1'b0;
            t_valid[3] = 1'b0;
            step();
            step();
            rst_n = 1'b1;
            repeat (VLAT + 3) step();
            @(negedge clk);
            chk("rst_rvalid", v, 3, 32'(r_valid), 32'd0);
            chk("rst_tready", v, 3, 32'(t_ready), 32'hF);
            chk("rst_idle", v, 3, 32'(idle), 32'd1);
            step();

            // Random traffic
            for (int k = 0; k < 400; k++) begin
                for (int i = 0; i < N; i++) begin
                    o_we[i]    = ($urandom_range(0, 3) == 0);
                    t_valid[i] = ($urandom_range(0, 3) != 0);
                    r_ready[i] = ($urandom_range(0, 4) < 3);
                    t_op[i*3 +: 3] = 3'($urandom_range(0, 7));
                    o_data[i*XLEN +: XLEN] = rnd32();
                    t_data[i*XLEN +: XLEN] = rnd32();
                end
                step();
            end
            t_valid = '0; o_we = '0; r_ready = '1;
            repeat (VLAT + VRD + 4) step();
            done_v = 1'b1;
        end
    end

    initial begin : top
        int t;
        t = 0;
        while (!(g_v[0].done_v && g_v[1].done_v && g_v[2].done_v && g_v[3].done_v)
               && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) begin
            mismatched++;
            $display("FAIL timeout: got %0d cycles expected completion under 20000", t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
